alu_issue_stage: RTL
====================

# alu_issue_stage

- Upstream neighbour of the ALU in the multi-cycle processor.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and reads two operands from an internal 8×32 register file.
- Drives the ALU's ip_0/ip_1/opcode inputs from registered operands, captures op_0/change_pc, and writes the result back to the register file.
- Fixed 4-state sequence; the ALU itself stays purely combinational outside this block.

## Interface
Parameters:
- DATA_W, 32, operand/result width (must match ALU).
- REG_N, 8, register-file depth (3-bit addresses).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  16  [15:13] ALU opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored.
- instr_ready  out  1  high only in IDLE.
- ext_we  in  1  external register write (preload); honoured only in IDLE.
- ext_addr  in  3  external write address.
- ext_wdata  in  32  external write data.
- dbg_addr  in  3  debug read address.
- dbg_data  out  32  combinational read of regfile[dbg_addr].
- alu_ip_0  out  32  to ALU ip_0; equals op_a register.
- alu_ip_1  out  32  to ALU ip_1; equals op_b register.
- alu_opcode  out  3  to ALU opcode; equals instr_q[15:13].
- alu_op_0  in  32  from ALU op_0.
- alu_change_pc  in  1  from ALU change_pc.
- result  out  32  captured ALU result.
- branch_taken  out  1  captured change_pc, valid when done=1.
- done  out  1  high for exactly the WB cycle.

## Operation
- States: IDLE → READ → EXEC → WB → IDLE; 2-bit state register.
- IDLE:
  - instr_ready=1.
  - On an edge with instr_valid=1: latch instr into instr_q and go to READ.
  - Otherwise stay in IDLE.
- READ: on the edge, load op_a=regfile[rs1] and op_b=regfile[rs2], then go to EXEC.
- EXEC:
  - ALU inputs are stable from op_a/op_b/instr_q.
  - On the edge, capture result=alu_op_0 and branch_taken=alu_change_pc, then go to WB.
- WB:
  - done=1.
  - On the edge, write result to regfile[rd] if the opcode writes and rd≠0, then go to IDLE.
- Compare opcodes 2 and 3 never write the regfile; only branch_taken is meaningful for them.
- All other opcodes (0,1,4,5,6,7) write rd.
- r0 is hardwired zero: reads return 0 and writes (internal or external) are dropped.
- External write:
  - Applied only on an edge where state=IDLE; ignored in other states, with no queuing.
  - If ext_we and an instruction acceptance fall on the same edge, both take effect. The instruction's READ then sees the new value.
- Width: results are stored truncated to DATA_W; no flags beyond change_pc.
- dbg_data reflects writes from the cycle after the write edge.

## Timing
- Reset (async assert, sync deassert by system):
  - state=IDLE; regfile all 0; op_a, op_b, instr_q, result = 0; branch_taken=0; done=0.
  - Consequently instr_ready=1 and alu_ip_0, alu_ip_1, alu_opcode = 0.
- Reset mid-operation aborts the instruction: no writeback, and outputs return to their reset values immediately.
- Latency: acceptance edge E → done high in cycle after E+2 edges. Regfile write at edge E+3; instr_ready high again after E+3.
- Throughput: one instruction per 4 cycles.
- There is no read-after-write hazard: the write at E+3 precedes the next READ at ≥E+5.
- instr_valid while not IDLE is ignored; the instruction is not accepted until ready=1.
- result and branch_taken hold their values until the next EXEC edge.

## Test plan
- Reset: hold rst_n=0 mid-EXEC → state IDLE, done=0, result=0, dbg_data=0 for all addresses, instr_ready=1 without waiting for a clock edge.
- Add path:
  - Stimulus: preload r1=10, r2=619; issue opcode 4, rd=3, rs1=1, rs2=2.
  - Response: during EXEC, alu_ip_0=10, alu_ip_1=619, alu_opcode=4.
  - Response: done one cycle later with result equal to the ALU's op_0; dbg_addr=3 returns that value after WB.
- Compare:
  - Stimulus: r1=5, r2=5; opcode 2, rd=4.
  - Response: branch_taken equals the ALU change_pc during done; r4 remains 0.
- r0 protection:
  - Stimulus: ext write r0=0xDEAD; then opcode 5 with rd=0, rs1=r0 operands 55 and 3 (r2 preset 3).
  - Response: alu_ip_0=0; r0 reads 0 after both writes.
- Back-to-back:
  - Stimulus: hold instr_valid=1 with two instructions, where the second reads the first's rd.
  - Response: acceptances exactly 4 cycles apart; the second's alu_ip_0 equals the first's result.
- Same-edge ext write plus accept:
  - Stimulus: ext_we r1=9 on the acceptance edge of an opcode 6 instruction reading rs1=1.
  - Response: alu_ip_0=9 in EXEC. An ext_we asserted during READ/EXEC/WB is ignored.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - issue stage feeding a combinational ALU from an 8x32 register file
// Runs IDLE -> READ -> EXEC -> WB for each accepted instruction.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              ext_we,
    input  logic [2:0]        ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] alu_ip_0,
    output logic [DATA_W-1:0] alu_ip_1,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_op_0,
    input  logic              alu_change_pc,
    output logic [DATA_W-1:0] result,
    output logic              branch_taken,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [DATA_W-1:0] regFile [REG_N];
    logic [11:0]       instrQ;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] resultQ;
    logic              branchQ;

    logic [2:0] opcodeQ;
    logic [2:0] rdQ;
    logic [2:0] rs1Q;
    logic [2:0] rs2Q;
    logic       writesRd;
    logic       unusedInstrBits;

    // Only instr[15:4] carries meaning; the low nibble is deliberately dropped.
    assign unusedInstrBits = ^instr[3:0];
    assign opcodeQ  = instrQ[11:9];
    assign rdQ      = instrQ[8:6];
    assign rs1Q     = instrQ[5:3];
    assign rs2Q     = instrQ[2:0];
    assign writesRd = (opcodeQ != 3'd2) && (opcodeQ != 3'd3);

    function automatic logic [DATA_W-1:0] readReg(input logic [2:0] addr);
        return (addr == 3'd0) ? '0 : regFile[addr];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (instr_valid) stateNext = READ;
            READ:    stateNext = EXEC;
            EXEC:    stateNext = WB;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:    instr_ready = 1'b1;
            WB:      done        = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrQ  <= '0;
            opA     <= '0;
            opB     <= '0;
            resultQ <= '0;
            branchQ <= 1'b0;
        end else begin
            case (state)
                IDLE: if (instr_valid) instrQ <= instr[15:4];
                READ: begin
                    opA <= readReg(rs1Q);
                    opB <= readReg(rs2Q);
                end
                EXEC: begin
                    resultQ <= alu_op_0;
                    branchQ <= alu_change_pc;
                end
                default: ;
            endcase
        end
    end

    // External preload and writeback live in disjoint states, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                regFile[i] <= '0;
            end
        end else if (state == IDLE) begin
            if (ext_we && (ext_addr != 3'd0)) regFile[ext_addr] <= ext_wdata;
        end else if (state == WB) begin
            if (writesRd && (rdQ != 3'd0)) regFile[rdQ] <= resultQ;
        end
    end

    assign dbg_data     = readReg(dbg_addr);
    assign alu_ip_0     = opA;
    assign alu_ip_1     = opB;
    assign alu_opcode   = opcodeQ;
    assign result       = resultQ;
    assign branch_taken = branchQ;

endmodule
